z4_cba: RTL and testbench
=========================

# z4_cba

4-bit carry-bypass (carry-skip) adder with registered outputs. It computes {c_out, sum} = a + b + c_in. A group-propagate signal lets the carry-in skip the internal ripple chain when every bit propagates. It is the base adder block for wider skip-adder chains, which cascade c_out into the next block's c_in.

## Interface
Parameters:
- None. Width is fixed at 4 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous and active-high. Clears the output registers.
- a  input  4  addend A (unsigned).
- b  input  4  addend B (unsigned).
- c_in  input  1  carry-in.
- sum  output  4  registered sum bits [3:0].
- c_out  output  1  registered carry-out.

## Operation
- Per bit i in 0..3:
  - p_i = a[i] ^ b[i]
  - g_i = a[i] & b[i]
- Ripple chain:
  - c_0 = c_in
  - c_{i+1} = g_i | (p_i & c_i)
  - s_i = p_i ^ c_i
- Group propagate: P = p_0 & p_1 & p_2 & p_3.
- Bypass mux: c_out_next = P ? c_in : c_4.
  - When P = 1, c_4 always equals c_in. The mux must still be built explicitly as the skip path; it must not be optimised into a plain ripple.
- sum_next = {s_3, s_2, s_1, s_0}.
- The result is arithmetically exact for all 512 input combinations: {c_out_next, sum_next} == a + b + c_in (5-bit, unsigned).
- No overflow flag and no signed interpretation.

## Timing
- Inputs are sampled on every rising clk edge. The result appears on sum/c_out after the same edge: one-cycle latency, throughput one add per cycle.
- No handshake. Every cycle's inputs produce a result.
- Reset values: sum = 4'h0, c_out = 0. Reset is applied on a rising edge with rst = 1 and overrides any add that cycle.
- Reset asserted mid-stream:
  - The result of the inputs on that edge is discarded.
  - The first valid result follows the first edge with rst = 0.
- Before the first clock edge the outputs are unspecified. The bench must assert rst before checking.
- Critical combinational path: c_in -> bypass mux -> c_out register. It must not traverse the 4-stage ripple chain.

## Structure
- No shared package is needed. If the team's adder package exists, it holds the width constant CBA_W = 4 for use by cascading wrappers.
- One sub-module, z_fa (1-bit full adder: a, b, cin -> s, cout, p, g), instantiated four times.
- The top level contains:
  - the ripple interconnect
  - the P AND-reduction
  - the bypass mux
  - the 5-bit output register with synchronous reset

## Test plan
- Reset: rst = 1 for 2 edges with a = F, b = F, c_in = 1 -> sum = 0, c_out = 0. Release rst; on the next edge, sum = F, c_out = 1.
- a = 0, b = 0, c_in = 1 -> one edge later sum = 1, c_out = 0. Then a = F, b = F, c_in = 1 -> one edge later sum = F, c_out = 1.
- Bypass path, a = 5, b = A (P = 1):
  - c_in = 1 -> sum = 0, c_out = 1.
  - c_in = 0 -> sum = F, c_out = 0.
- Ripple path, a = 7, b = 1, c_in = 0 (P = 0) -> sum = 8, c_out = 0. Then a = 8, b = 8, c_in = 0 -> sum = 0, c_out = 1.
- Back-to-back: apply new inputs on every edge for 3 cycles. Each result must match the previous edge's inputs, with no bubbles.
- Exhaustive: all 512 {a, b, c_in} combinations at one per cycle, with rst = 1 inserted once mid-sweep. {c_out, sum} must equal a + b + c_in delayed by one cycle, except the reset cycle, which must read 0.

Source files
------------

// File: rtl/z4_cba_pkg.sv
// Shared constants and the result payload type for the 4-bit carry-bypass adder.
package z4_cba_pkg;

  localparam int unsigned CBA_W = 4;

  typedef struct packed {
    logic             c_out;
    logic [CBA_W-1:0] sum;
  } cba_res_t;

endpackage

// File: rtl/z4_cba_fa.sv
// 1-bit full adder exposing its propagate/generate terms for the skip logic.
module z_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout,
  output logic p,
  output logic g
);

  assign p    = a ^ b;
  assign g    = a & b;
  assign s    = p ^ cin;
  assign cout = g | (p & cin);

endmodule

// File: rtl/z4_cba.sv
// 4-bit carry-bypass adder: ripple chain plus a group-propagate skip mux,
// with a registered 5-bit result.
module z4_cba
  import z4_cba_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CBA_W-1:0] a,
  input  logic [CBA_W-1:0] b,
  input  logic             c_in,
  output logic [CBA_W-1:0] sum,
  output logic             c_out
);

  logic [CBA_W:0]   carry;
  logic [CBA_W-1:0] p;
  logic [CBA_W-1:0] g;
  logic [CBA_W-1:0] s;
  logic             group_p;
  logic             bypass;
  logic             unused_g;
  cba_res_t         res_next;
  cba_res_t         res_q;

  assign carry[0] = c_in;

  // Ripple interconnect across the four full-adder cells.
  for (genvar i = 0; i < int'(CBA_W); i++) begin : g_fa
    z_fa u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (s[i]),
      .cout (carry[i+1]),
      .p    (p[i]),
      .g    (g[i])
    );
  end

  // Generate terms are already folded into each cell's carry-out.
  assign unused_g = ^g;

  // Skip path: when every bit propagates, c_in goes straight to the register.
  assign group_p = &p;
  assign bypass  = group_p ? c_in : carry[CBA_W];

  always_comb begin
    res_next       = '0;
    res_next.c_out = bypass;
    res_next.sum   = s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else begin
      res_q <= res_next;
    end
  end

  assign sum   = res_q.sum;
  assign c_out = res_q.c_out;

endmodule

// File: tb/tb_z4_cba.sv
// Directed and exhaustive self-checking bench for the z4_cba carry-bypass adder.
module tb_z4_cba;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       c_in;
  logic [3:0] sum;
  logic       c_out;

  int compared;
  int mismatched;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       c_in;
    logic [3:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[12];

  z4_cba dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got {c_out,sum}=%b_%h required %b_%h",
               name, got[4], got[3:0], exp[4], exp[3:0]);
    end
  endtask

  task automatic apply(input logic r, input logic [3:0] va, input logic [3:0] vb,
                       input logic vc);
    rst  = r;
    a    = va;
    b    = vb;
    c_in = vc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] exp;
    compared   = 0;
    mismatched = 0;
    rst  = 1'b1;
    a    = 4'h0;
    b    = 4'h0;
    c_in = 1'b0;

    vecs[0]  = '{"reset_0",      1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0};
    vecs[1]  = '{"reset_1",      1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0};
    vecs[2]  = '{"release",      1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    vecs[3]  = '{"zero_cin",     1'b0, 4'h0, 4'h0, 1'b1, 4'h1, 1'b0};
    vecs[4]  = '{"max_cin",      1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    vecs[5]  = '{"bypass_cin1",  1'b0, 4'h5, 4'hA, 1'b1, 4'h0, 1'b1};
    vecs[6]  = '{"bypass_cin0",  1'b0, 4'h5, 4'hA, 1'b0, 4'hF, 1'b0};
    vecs[7]  = '{"ripple_7p1",   1'b0, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0};
    vecs[8]  = '{"ripple_8p8",   1'b0, 4'h8, 4'h8, 1'b0, 4'h0, 1'b1};
    vecs[9]  = '{"b2b_0",        1'b0, 4'h3, 4'h4, 1'b0, 4'h7, 1'b0};
    vecs[10] = '{"b2b_1",        1'b0, 4'h9, 4'h9, 1'b1, 4'h3, 1'b1};
    vecs[11] = '{"b2b_2",        1'b0, 4'hC, 4'h3, 1'b1, 4'h0, 1'b1};

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].c_in);
      check(vecs[i].name, {c_out, sum}, {vecs[i].exp_cout, vecs[i].exp_sum});
    end

    // Mid-stream reset discards the add on that edge; the next edge is valid again.
    apply(1'b0, 4'h2, 4'h3, 1'b0);
    check("pre_rst", {c_out, sum}, 5'h05);
    apply(1'b1, 4'h6, 4'h6, 1'b1);
    check("mid_rst", {c_out, sum}, 5'h00);
    apply(1'b0, 4'h1, 4'h1, 1'b0);
    check("post_rst", {c_out, sum}, 5'h02);

    // Exhaustive sweep, one combination per cycle, one reset cycle inserted.
    for (int k = 0; k < 512; k++) begin
      logic [8:0] v;
      logic       r;
      v = 9'(k);
      r = (k == 300);
      apply(r, v[8:5], v[4:1], v[0]);
      exp = r ? 5'h00 : 5'(v[8:5]) + 5'(v[4:1]) + 5'(v[0]);
      check($sformatf("sweep_%0d", k), {c_out, sum}, exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
